// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO decoupling instruction fetch from decode.
// Holds each fetched instruction with its PC, PC+4 and branch-prediction
// side-band. Supports a single-cycle misprediction flush.
module fetch_queue #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PC_SIZE    = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic                          flush_in,

    input  logic                          enq_valid_in,
    output logic                          enq_ready_out,
    input  logic [DATA_WIDTH-1:0]         enq_inst_in,
    input  logic [PC_SIZE-1:0]            enq_pc_in,
    input  logic [PC_SIZE-1:0]            enq_pc4_in,
    input  logic                          enq_is_cond_br_in,
    input  logic                          enq_is_jal_in,
    input  logic                          enq_is_jalr_in,
    input  logic                          enq_predict_taken_in,
    input  logic [DATA_WIDTH-1:0]         enq_predict_pc_in,

    output logic                          deq_valid_out,
    input  logic                          deq_ready_in,
    output logic [DATA_WIDTH-1:0]         deq_inst_out,
    output logic [PC_SIZE-1:0]            deq_pc_out,
    output logic [PC_SIZE-1:0]            deq_pc4_out,
    output logic                          deq_is_cond_br_out,
    output logic                          deq_is_jal_out,
    output logic                          deq_is_jalr_out,
    output logic                          deq_predict_taken_out,
    output logic [DATA_WIDTH-1:0]         deq_predict_pc_out,

    output logic [$clog2(DEPTH+1)-1:0]    count_out,
    output logic                          empty_out,
    output logic                          full_out
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] inst;
        logic [PC_SIZE-1:0]    pc;
        logic [PC_SIZE-1:0]    pc4;
        logic                  is_cond_br;
        logic                  is_jal;
        logic                  is_jalr;
        logic                  predict_taken;
        logic [DATA_WIDTH-1:0] predict_pc;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    entry_t             enq_entry;
    entry_t             head_entry;
    logic               enq_fire;
    logic               deq_fire;

    // Pack the incoming fetch bundle into one storage word
    assign enq_entry = '{
        inst:          enq_inst_in,
        pc:            enq_pc_in,
        pc4:           enq_pc4_in,
        is_cond_br:    enq_is_cond_br_in,
        is_jal:        enq_is_jal_in,
        is_jalr:       enq_is_jalr_in,
        predict_taken: enq_predict_taken_in,
        predict_pc:    enq_predict_pc_in
    };

    // Status flags derive only from the registered count
    assign empty_out     = (count_q == '0);
    assign full_out      = (count_q == CNT_W'(DEPTH));
    assign enq_ready_out = !full_out;
    assign deq_valid_out = !empty_out;
    assign count_out     = count_q;

    assign enq_fire = enq_valid_in && enq_ready_out;
    assign deq_fire = deq_valid_out && deq_ready_in;

    // Head entry is read straight from the array at the read pointer
    assign head_entry            = mem_q[rd_ptr_q];
    assign deq_inst_out          = head_entry.inst;
    assign deq_pc_out            = head_entry.pc;
    assign deq_pc4_out           = head_entry.pc4;
    assign deq_is_cond_br_out    = head_entry.is_cond_br;
    assign deq_is_jal_out        = head_entry.is_jal;
    assign deq_is_jalr_out       = head_entry.is_jalr;
    assign deq_predict_taken_out = head_entry.predict_taken;
    assign deq_predict_pc_out    = head_entry.predict_pc;

    // Next-state for pointers and occupancy; flush overrides all traffic
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq_fire) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (deq_fire) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (enq_fire && !deq_fire) begin
                count_d = count_q + CNT_W'(1);
            end else if (deq_fire && !enq_fire) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are left untouched by a flush
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (!flush_in && enq_fire) begin
            mem_q[wr_ptr_q] <= enq_entry;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed, scoreboard-checked bench for fetch_queue.
module tb_fetch_queue;

    localparam int unsigned DW    = 32;
    localparam int unsigned PW    = 32;
    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [DW-1:0] inst;
        logic [PW-1:0] pc;
        logic [PW-1:0] pc4;
        logic          is_cond_br;
        logic          is_jal;
        logic          is_jalr;
        logic          predict_taken;
        logic [DW-1:0] predict_pc;
    } ent_t;

    logic          clk;
    logic          arst_n;
    logic          flush_in;
    logic          enq_valid_in;
    logic          enq_ready_out;
    logic [DW-1:0] enq_inst_in;
    logic [PW-1:0] enq_pc_in;
    logic [PW-1:0] enq_pc4_in;
    logic          enq_is_cond_br_in;
    logic          enq_is_jal_in;
    logic          enq_is_jalr_in;
    logic          enq_predict_taken_in;
    logic [DW-1:0] enq_predict_pc_in;
    logic          deq_valid_out;
    logic          deq_ready_in;
    logic [DW-1:0] deq_inst_out;
    logic [PW-1:0] deq_pc_out;
    logic [PW-1:0] deq_pc4_out;
    logic          deq_is_cond_br_out;
    logic          deq_is_jal_out;
    logic          deq_is_jalr_out;
    logic          deq_predict_taken_out;
    logic [DW-1:0] deq_predict_pc_out;
    logic [2:0]    count_out;
    logic          empty_out;
    logic          full_out;

    int   tests_run;
    int   tests_failed;
    ent_t sb[$];

    fetch_queue #(.DATA_WIDTH(DW), .PC_SIZE(PW), .DEPTH(DEPTH)) dut (
        .clk                   (clk),
        .arst_n                (arst_n),
        .flush_in              (flush_in),
        .enq_valid_in          (enq_valid_in),
        .enq_ready_out         (enq_ready_out),
        .enq_inst_in           (enq_inst_in),
        .enq_pc_in             (enq_pc_in),
        .enq_pc4_in            (enq_pc4_in),
        .enq_is_cond_br_in     (enq_is_cond_br_in),
        .enq_is_jal_in         (enq_is_jal_in),
        .enq_is_jalr_in        (enq_is_jalr_in),
        .enq_predict_taken_in  (enq_predict_taken_in),
        .enq_predict_pc_in     (enq_predict_pc_in),
        .deq_valid_out         (deq_valid_out),
        .deq_ready_in          (deq_ready_in),
        .deq_inst_out          (deq_inst_out),
        .deq_pc_out            (deq_pc_out),
        .deq_pc4_out           (deq_pc4_out),
        .deq_is_cond_br_out    (deq_is_cond_br_out),
        .deq_is_jal_out        (deq_is_jal_out),
        .deq_is_jalr_out       (deq_is_jalr_out),
        .deq_predict_taken_out (deq_predict_taken_out),
        .deq_predict_pc_out    (deq_predict_pc_out),
        .count_out             (count_out),
        .empty_out             (empty_out),
        .full_out              (full_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Distinct, pc-derived payload so misordering or field swaps show up
    function automatic ent_t make(input logic [31:0] pc);
        ent_t e;
        e.inst          = {pc[15:0], 16'hA5C3} ^ 32'h1357_0000;
        e.pc            = pc;
        e.pc4           = pc + 32'd4;
        e.is_cond_br    = pc[2];
        e.is_jal        = pc[3];
        e.is_jalr       = pc[4];
        e.predict_taken = pc[2] ^ pc[3];
        e.predict_pc    = pc + 32'h0000_0440;
        return e;
    endfunction

    function automatic ent_t head_obs();
        return {deq_inst_out, deq_pc_out, deq_pc4_out, deq_is_cond_br_out,
                deq_is_jal_out, deq_is_jalr_out, deq_predict_taken_out,
                deq_predict_pc_out};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ent(input string tag, input ent_t obs, input ent_t exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Status outputs against the scoreboard occupancy
    task automatic chk_status(input string tag);
        int n;
        n = sb.size();
        chk({tag, ".count"}, 64'(count_out), 64'(n));
        chk({tag, ".deq_valid"}, 64'(deq_valid_out), 64'(n != 0));
        chk({tag, ".enq_ready"}, 64'(enq_ready_out), 64'(n < DEPTH));
        chk({tag, ".full"}, 64'(full_out), 64'(n == DEPTH));
        chk({tag, ".empty"}, 64'(empty_out), 64'(n == 0));
    endtask

    // One clock of stimulus: check head/status before the edge, update model at the edge
    task automatic cycle(input string tag, input logic ev, input logic [31:0] pc,
                         input logic dr, input logic fl);
        ent_t e;
        logic efire, dfire;
        e = make(pc);
        enq_valid_in         = ev;
        enq_inst_in          = e.inst;
        enq_pc_in            = e.pc;
        enq_pc4_in           = e.pc4;
        enq_is_cond_br_in    = e.is_cond_br;
        enq_is_jal_in        = e.is_jal;
        enq_is_jalr_in       = e.is_jalr;
        enq_predict_taken_in = e.predict_taken;
        enq_predict_pc_in    = e.predict_pc;
        deq_ready_in         = dr;
        flush_in             = fl;
        #1;
        chk_status(tag);
        if (sb.size() > 0) chk_ent({tag, ".head"}, head_obs(), sb[0]);
        efire = ev && (sb.size() < DEPTH);
        dfire = dr && (sb.size() > 0);
        @(posedge clk);
        #1;
        if (fl) begin
            sb.delete();
        end else begin
            if (dfire) void'(sb.pop_front());
            if (efire) sb.push_back(e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        arst_n       = 1'b0;
        flush_in     = 1'b0;
        enq_valid_in = 1'b0;
        deq_ready_in = 1'b0;
        enq_inst_in = '0; enq_pc_in = '0; enq_pc4_in = '0;
        enq_is_cond_br_in = 1'b0; enq_is_jal_in = 1'b0; enq_is_jalr_in = 1'b0;
        enq_predict_taken_in = 1'b0; enq_predict_pc_in = '0;

        // Reset state
        #12;
        chk_status("reset");
        chk_ent("reset.head", head_obs(), '0);
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;

        // Idle with decode ready: nothing changes
        for (int i = 0; i < 3; i++) cycle("idle", 1'b0, 32'h0, 1'b1, 1'b0);
        chk_ent("idle.head", head_obs(), '0);

        // Fill to full, then a 5th entry must be refused
        for (int i = 0; i < 4; i++) cycle("fill", 1'b1, 32'(i * 4), 1'b0, 1'b0);
        chk("fill.full", 64'(full_out), 64'd1);
        cycle("overfill", 1'b1, 32'h10, 1'b0, 1'b0);
        cycle("hold", 1'b0, 32'h0, 1'b0, 1'b0);

        // Drain in order with side-band intact
        for (int i = 0; i < 4; i++) cycle("drain", 1'b0, 32'h0, 1'b1, 1'b0);
        cycle("drained", 1'b0, 32'h0, 1'b1, 1'b0);

        // Streaming with both sides always ready; pointers wrap twice
        for (int i = 0; i < 10; i++) cycle("stream", 1'b1, 32'h400 + 32'(i * 4), 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) cycle("stream_tail", 1'b0, 32'h0, 1'b1, 1'b0);

        // Simultaneous enq+deq at count=2
        cycle("c2a", 1'b1, 32'h500, 1'b0, 1'b0);
        cycle("c2b", 1'b1, 32'h504, 1'b0, 1'b0);
        cycle("c2both", 1'b1, 32'h508, 1'b1, 1'b0);
        chk("c2.count", 64'(count_out), 64'd2);

        // Simultaneous enq+deq when full: only the dequeue happens
        cycle("c4a", 1'b1, 32'h50C, 1'b0, 1'b0);
        cycle("c4b", 1'b1, 32'h510, 1'b0, 1'b0);
        cycle("c4both", 1'b1, 32'h514, 1'b1, 1'b0);
        chk("c4.count", 64'(count_out), 64'd3);

        // Flush at count=3 with concurrent traffic
        cycle("flush", 1'b1, 32'h200, 1'b1, 1'b1);
        chk("flush.count", 64'(count_out), 64'd0);
        chk("flush.valid", 64'(deq_valid_out), 64'd0);
        cycle("postflush", 1'b1, 32'h100, 1'b0, 1'b0);
        cycle("postflush_deq", 1'b0, 32'h0, 1'b1, 1'b0);
        cycle("postflush_empty", 1'b0, 32'h0, 1'b0, 1'b0);

        // Async reset mid-cycle at count=2
        cycle("pre_rst_a", 1'b1, 32'h600, 1'b0, 1'b0);
        cycle("pre_rst_b", 1'b1, 32'h604, 1'b0, 1'b0);
        enq_valid_in = 1'b0;
        deq_ready_in = 1'b0;
        #1;
        chk("pre_rst.count", 64'(count_out), 64'd2);
        arst_n = 1'b0;
        #1;
        sb.delete();
        chk_status("async_rst");
        chk_ent("async_rst.head", head_obs(), '0);
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) cycle("after_rst", 1'b1, 32'h700 + 32'(i * 4), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle("after_rst_drain", 1'b0, 32'h0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
